// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer, PC carry and flush.
// Optional per-class delivery counters are enabled by defining DECODE_STATS_EN.
module instr_decode_stage #(
    parameter int INSTR_W  = 32,
    parameter int DATA_W   = 32,
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int FUNCT_W  = 6,
    parameter int IMM_W    = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [INSTR_W-1:0]                            in_instr,
    input  logic [DATA_W-1:0]                             in_pc,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_W-1:0]                             out_pc,
    output logic [OPCODE_W-1:0]                           opcode,
    output logic [REG_W-1:0]                              rs,
    output logic [REG_W-1:0]                              rt,
    output logic [REG_W-1:0]                              rd,
    output logic [INSTR_W-OPCODE_W-3*REG_W-FUNCT_W-1:0]   shamt,
    output logic [FUNCT_W-1:0]                            funct,
    output logic [DATA_W-1:0]                             imm_ext,
    output logic [INSTR_W-OPCODE_W-1:0]                   jtarget,
    output logic                                          is_rtype,
    output logic                                          is_itype,
    output logic                                          is_jtype
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]                                   cnt_r,
    output logic [31:0]                                   cnt_i,
    output logic [31:0]                                   cnt_j
`endif
);

    localparam int SH_W = INSTR_W - OPCODE_W - 3 * REG_W - FUNCT_W;
    localparam int JT_W = INSTR_W - OPCODE_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]   pc;
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [SH_W-1:0]     shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [DATA_W-1:0]   imm_ext;
        logic [JT_W-1:0]     jtarget;
        logic                is_r;
        logic                is_i;
        logic                is_j;
    } entry_t;

    state_e count_q, count_d;
    logic   in_ready_q, in_ready_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry;
    entry_t head_vis;
    logic   push, pop;

    // Decode happens on entry so the buffer holds fully decoded fields.
    always_comb begin
        logic [IMM_W-1:0] imm;
        imm                = in_instr[IMM_W-1:0];
        new_entry          = '0;
        new_entry.pc       = in_pc;
        new_entry.opcode   = in_instr[INSTR_W-1 -: OPCODE_W];
        new_entry.rs       = in_instr[INSTR_W-OPCODE_W-1 -: REG_W];
        new_entry.rt       = in_instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
        new_entry.rd       = in_instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
        new_entry.shamt    = in_instr[FUNCT_W +: SH_W];
        new_entry.funct    = in_instr[FUNCT_W-1:0];
        new_entry.jtarget  = in_instr[JT_W-1:0];
        new_entry.is_r     = (new_entry.opcode == OPCODE_W'(0));
        new_entry.is_j     = (new_entry.opcode == OPCODE_W'(2)) || (new_entry.opcode == OPCODE_W'(3));
        new_entry.is_i     = !new_entry.is_r && !new_entry.is_j;
        if ((new_entry.opcode == OPCODE_W'(12)) || (new_entry.opcode == OPCODE_W'(13)) ||
            (new_entry.opcode == OPCODE_W'(14))) begin
            new_entry.imm_ext            = '0;
            new_entry.imm_ext[IMM_W-1:0] = imm;
        end else if (new_entry.opcode == OPCODE_W'(15)) begin
            new_entry.imm_ext                    = '0;
            new_entry.imm_ext[DATA_W-1 -: IMM_W] = imm;
        end else begin
            new_entry.imm_ext            = {DATA_W{imm[IMM_W-1]}};
            new_entry.imm_ext[IMM_W-1:0] = imm;
        end
    end

    assign out_valid = (count_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = EMPTY;
        end else begin
            unique case (count_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        count_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        count_d = FULL;
                    end else if (pop) begin
                        count_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = ONE;
                    end
                end
                default: count_d = EMPTY;
            endcase
        end
        // Registered so in_ready never sees out_ready combinationally.
        in_ready_d = (count_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments; control resets, payload does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: buffer payload is not reset; it is only observed through out_valid gating.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    always_comb begin
        head_vis = out_valid ? head_q : '0;
        out_pc   = head_vis.pc;
        opcode   = head_vis.opcode;
        rs       = head_vis.rs;
        rt       = head_vis.rt;
        rd       = head_vis.rd;
        shamt    = head_vis.shamt;
        funct    = head_vis.funct;
        imm_ext  = head_vis.imm_ext;
        jtarget  = head_vis.jtarget;
        is_rtype = head_vis.is_r;
        is_itype = head_vis.is_i;
        is_jtype = head_vis.is_j;
    end

`ifdef DECODE_STATS_EN
    logic [31:0] cnt_r_q, cnt_r_d;
    logic [31:0] cnt_i_q, cnt_i_d;
    logic [31:0] cnt_j_q, cnt_j_d;

    // Counted on delivery, including a pop that coincides with flush; saturating.
    always_comb begin
        cnt_r_d = cnt_r_q;
        cnt_i_d = cnt_i_q;
        cnt_j_d = cnt_j_q;
        if (pop && head_q.is_r && (cnt_r_q != '1)) cnt_r_d = cnt_r_q + 32'd1;
        if (pop && head_q.is_i && (cnt_i_q != '1)) cnt_i_d = cnt_i_q + 32'd1;
        if (pop && head_q.is_j && (cnt_j_q != '1)) cnt_j_d = cnt_j_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r_q <= '0;
            cnt_i_q <= '0;
            cnt_j_q <= '0;
        end else begin
            cnt_r_q <= cnt_r_d;
            cnt_i_q <= cnt_i_d;
            cnt_j_q <= cnt_j_d;
        end
    end

    assign cnt_r = cnt_r_q;
    assign cnt_i = cnt_i_q;
    assign cnt_j = cnt_j_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage with a scoreboard of expected decoded entries.
// Define DECODE_STATS_EN to also check the delivery counters.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [25:0] jtarget;
    logic        is_rtype, is_itype, is_jtype;
`ifdef DECODE_STATS_EN
    logic [31:0] cnt_r, cnt_i, cnt_j;
    int unsigned exp_r = 0, exp_i = 0, exp_j = 0;
`endif

    instr_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_ext(imm_ext), .jtarget(jtarget),
        .is_rtype(is_rtype), .is_itype(is_itype), .is_jtype(is_jtype)
`ifdef DECODE_STATS_EN
        , .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_j(cnt_j)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [25:0] jt;
        logic        r, i, j;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode for the default 32-bit MIPS-style layout.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.pc     = pc;
        e.opcode = ins[31:26];
        e.rs     = ins[25:21];
        e.rt     = ins[20:16];
        e.rd     = ins[15:11];
        e.shamt  = ins[10:6];
        e.funct  = ins[5:0];
        e.jt     = ins[25:0];
        case (e.opcode)
            6'h0C, 6'h0D, 6'h0E: e.imm = {16'h0000, ins[15:0]};
            6'h0F:               e.imm = {ins[15:0], 16'h0000};
            default:             e.imm = {{16{ins[15]}}, ins[15:0]};
        endcase
        e.r = (e.opcode == 6'd0);
        e.j = (e.opcode == 6'd2) || (e.opcode == 6'd3);
        e.i = !e.r && !e.j;
        return e;
    endfunction

    task automatic check_head(input exp_t e);
        check("out_pc",   out_pc,   e.pc);
        check("opcode",   opcode,   e.opcode);
        check("rs",       rs,       e.rs);
        check("rt",       rt,       e.rt);
        check("rd",       rd,       e.rd);
        check("shamt",    shamt,    e.shamt);
        check("funct",    funct,    e.funct);
        check("imm_ext",  imm_ext,  e.imm);
        check("jtarget",  jtarget,  e.jt);
        check("is_rtype", is_rtype, e.r);
        check("is_itype", is_itype, e.i);
        check("is_jtype", is_jtype, e.j);
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, output logic accepted);
        exp_t e;
        logic pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        accepted  = v && in_ready && !fl;
        pop       = out_valid && ordy;
        if (out_valid) begin
            if (sb.size() == 0) check("unexpected_out_valid", 1'b1, 1'b0);
            else check_head(sb[0]);
        end
        if (pop && sb.size() > 0) begin
            e = sb.pop_front();
`ifdef DECODE_STATS_EN
            if (e.r) exp_r++;
            if (e.i) exp_i++;
            if (e.j) exp_j++;
`endif
        end
        if (fl) sb.delete();
        else if (v && in_ready) sb.push_back(ref_decode(ins, pc));
        @(posedge clk);
        #1;
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready",  in_ready,  sb.size() < 2);
        if (!out_valid) begin
            check("idle_imm_ext", imm_ext, 32'h0);
            check("idle_class", {is_rtype, is_itype, is_jtype}, 3'b000);
        end
    endtask

`ifdef DECODE_STATS_EN
    task automatic check_stats(input string tag);
        check({tag, "_cnt_r"}, cnt_r, exp_r);
        check({tag, "_cnt_i"}, cnt_i, exp_i);
        check({tag, "_cnt_j"}, cnt_j, exp_j);
    endtask
`endif

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        sb.delete();
`ifdef DECODE_STATS_EN
        exp_r = 0; exp_i = 0; exp_j = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_opcode",    opcode,    6'h0);
        check("rst_out_pc",    out_pc,    32'h0);
`ifdef DECODE_STATS_EN
        check_stats("rst");
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready",  in_ready,  1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   guard;
        #1;
        do_reset();

        // R-type decode
        cycle(1'b1, 32'h012A4020, 32'h0000_0100, 1'b1, 1'b0, acc);
        check("r_out_valid", out_valid, 1'b1);
        check("r_rs", rs, 5'd9);
        check("r_rt", rt, 5'd10);
        check("r_rd", rd, 5'd8);
        check("r_funct", funct, 6'h20);
        check("r_class", {is_rtype, is_itype, is_jtype}, 3'b100);

        // Immediate extension variants, pushed back-to-back while draining
        cycle(1'b1, 32'h2128FFFF, 32'h0000_0104, 1'b1, 1'b0, acc);
        check("addi_imm", imm_ext, 32'hFFFF_FFFF);
        check("addi_rt", rt, 5'd8);
        check("addi_itype", is_itype, 1'b1);
        cycle(1'b1, 32'h3528FFFF, 32'h0000_0108, 1'b1, 1'b0, acc);
        check("ori_imm", imm_ext, 32'h0000_FFFF);
        cycle(1'b1, 32'h3C081234, 32'h0000_010C, 1'b1, 1'b0, acc);
        check("lui_imm", imm_ext, 32'h1234_0000);

        // J-type
        cycle(1'b1, 32'h08000010, 32'h0040_0000, 1'b1, 1'b0, acc);
        check("j_jtype", is_jtype, 1'b1);
        check("j_jtarget", jtarget, 26'h0000010);
        check("j_out_pc", out_pc, 32'h0040_0000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Backpressure: two accepted, third held until space frees up
        cycle(1'b1, 32'h00851022, 32'h0000_0200, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h8C43FFF8, 32'h0000_0204, 1'b0, 1'b0, acc);
        check("bp_in_ready_low", in_ready, 1'b0);
        cycle(1'b1, 32'h0C000123, 32'h0000_0208, 1'b0, 1'b0, acc);
        check("bp_third_held", acc, 1'b0);
        cycle(1'b1, 32'h0C000123, 32'h0000_0208, 1'b0, 1'b0, acc);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 8) begin
            cycle(1'b1, 32'h0C000123, 32'h0000_0208, 1'b1, 1'b0, acc);
            guard++;
        end
        check("bp_third_accepted", acc, 1'b1);
        guard = 0;
        while (sb.size() != 0 && guard < 8) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
            guard++;
        end
        check("bp_drained", sb.size(), 0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
`ifdef DECODE_STATS_EN
        check_stats("delivered");
`endif

        // Flush from FULL with a simultaneous push
        cycle(1'b1, 32'h20010001, 32'h0000_0300, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00000000, 32'h0000_0304, 1'b0, 1'b0, acc);
        check("fl_full", in_ready, 1'b0);
        cycle(1'b1, 32'h0800ABCD, 32'h0000_0308, 1'b0, 1'b1, acc);
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
`ifdef DECODE_STATS_EN
        check_stats("after_flush");
`endif

        // Reset clears counters and buffer
        do_reset();
        cycle(1'b1, 32'h3C08BEEF, 32'h0000_0400, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
